// File: rtl/act_vec_packer_if.sv
// Handshake and output bus between an accumulator source, act_vec_packer and the
// activation input. The master side drives the accumulator stream; slave is the packer.
interface act_vec_packer_if #(
  parameter int unsigned BUS_NUM          = 8,
  parameter int unsigned FIXED_DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH        = 24,
  parameter int unsigned SCALA_POS_WIDTH  = 5
);
  logic [SCALA_POS_WIDTH-1:0]          cfg_shift;
  logic [ACC_WIDTH-1:0]                in_acc_data;
  logic                                in_acc_vld;
  logic                                in_acc_last;
  logic                                in_acc_rdy;
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] out_fixed_data;
  logic [BUS_NUM-1:0]                  out_fixed_data_vld;

  modport master (
    output cfg_shift, in_acc_data, in_acc_vld, in_acc_last,
    input  in_acc_rdy, out_fixed_data, out_fixed_data_vld
  );

  modport slave (
    input  cfg_shift, in_acc_data, in_acc_vld, in_acc_last,
    output in_acc_rdy, out_fixed_data, out_fixed_data_vld
  );
endinterface

// File: rtl/act_vec_packer.sv
// Requantises a serial accumulator stream (shift + saturate) and packs it into a
// BUS_NUM-lane vector emitted for one cycle. Define ACT_VEC_PACKER_ROUND_EN for round-half-up.
module act_vec_packer #(
  parameter int unsigned BUS_NUM          = 8,
  parameter int unsigned FIXED_DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH        = 24,
  parameter int unsigned SCALA_POS_WIDTH  = 5
) (
  input logic             clk,
  input logic             rst_n,
  act_vec_packer_if.slave bus
);
  localparam int unsigned CW = (BUS_NUM > 1) ? $clog2(BUS_NUM) : 1;
  localparam int unsigned DW = BUS_NUM * FIXED_DATA_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    (ACC_WIDTH+1)'((1 << (FIXED_DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {ST_RST, ST_FILL, ST_EMIT} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                lane_q;
  logic [SCALA_POS_WIDTH-1:0]   shift_q, shift_eff;
  logic [DW-1:0]                stage_data_q, merged_data, out_data_q;
  logic [BUS_NUM-1:0]           stage_vld_q, merged_vld, out_vld_q;
  logic                         rdy_q, accept, vec_end;
  logic signed [ACC_WIDTH:0]    ext, biased, shifted;
  logic [FIXED_DATA_WIDTH-1:0]  lane_val;

  assign accept  = bus.in_acc_vld & rdy_q;
  assign vec_end = accept & ((lane_q == CW'(BUS_NUM - 1)) | bus.in_acc_last);

  // Lane 0 uses the live shift; the rest of the vector reuses the value latched with it.
  assign shift_eff = (lane_q == '0) ? bus.cfg_shift : shift_q;

  assign bus.in_acc_rdy         = rdy_q;
  assign bus.out_fixed_data     = out_data_q;
  assign bus.out_fixed_data_vld = out_vld_q;

  always_comb begin
    ext    = {bus.in_acc_data[ACC_WIDTH-1], bus.in_acc_data};
    biased = ext;
`ifdef ACT_VEC_PACKER_ROUND_EN
    if (shift_eff != '0 && 32'(shift_eff) <= ACC_WIDTH)
      biased = ext + ((ACC_WIDTH+1)'(1) << (shift_eff - SCALA_POS_WIDTH'(1)));
`endif
    shifted = biased >>> shift_eff;
    if (shifted > SAT_MAX)      lane_val = SAT_MAX[FIXED_DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) lane_val = SAT_MIN[FIXED_DATA_WIDTH-1:0];
    else                        lane_val = shifted[FIXED_DATA_WIDTH-1:0];
  end

  // Staging contents with the word accepted this cycle already merged in, so the
  // final word of a vector reaches the output on the same edge it is accepted.
  always_comb begin
    merged_data = stage_data_q;
    merged_vld  = stage_vld_q;
    for (int unsigned i = 0; i < BUS_NUM; i++) begin
      if (accept && lane_q == CW'(i)) begin
        merged_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] = lane_val;
        merged_vld[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_FILL;
      ST_FILL: if (vec_end) state_d = ST_EMIT;
      ST_EMIT: state_d = ST_FILL;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST;
      rdy_q        <= 1'b0;
      lane_q       <= '0;
      shift_q      <= '0;
      stage_data_q <= '0;
      stage_vld_q  <= '0;
      out_data_q   <= '0;
      out_vld_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_FILL);
      if (accept && lane_q == '0)
        shift_q <= bus.cfg_shift;
      if (vec_end) begin
        out_data_q   <= merged_data;
        out_vld_q    <= merged_vld;
        stage_data_q <= '0;
        stage_vld_q  <= '0;
        lane_q       <= '0;
      end else begin
        out_vld_q <= '0;
        if (accept) begin
          stage_data_q <= merged_data;
          stage_vld_q  <= merged_vld;
          lane_q       <= lane_q + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_act_vec_packer.sv
// Directed bench for act_vec_packer: a per-cycle reference model of vector packing
// and requantisation plus literal expectations for each scenario.
module tb_act_vec_packer;
  localparam int unsigned BN = 4;
  localparam int unsigned FW = 8;
  localparam int unsigned AW = 24;
  localparam int unsigned SW = 5;

`ifdef ACT_VEC_PACKER_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  act_vec_packer_if #(.BUS_NUM(BN), .FIXED_DATA_WIDTH(FW), .ACC_WIDTH(AW),
                      .SCALA_POS_WIDTH(SW)) bus ();

  act_vec_packer #(.BUS_NUM(BN), .FIXED_DATA_WIDTH(FW), .ACC_WIDTH(AW),
                   .SCALA_POS_WIDTH(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane8(input int v);
    return v[7:0];
  endfunction

  // Reference requantisation with plain integer arithmetic.
  function automatic int requant(input int acc, input int sh);
    longint v;
    longint hi, lo;
    hi = (longint'(1) << (FW - 1)) - 1;
    lo = -(longint'(1) << (FW - 1));
    v = acc;
    if (ROUND && sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return int'(v);
  endfunction

  // Reference model state
  int                 post_edges = 0;
  int                 emit_cnt   = 0;
  int                 m_lane     = 0;
  int                 m_shift    = 0;
  int                 m_val [BN];
  bit                 m_w   [BN];
  bit                 emit_due   = 1'b0;
  logic [BN*FW-1:0]   pend_data  = '0;
  logic [BN-1:0]      pend_vld   = '0;
  logic [BN*FW-1:0]   exp_data   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) post_edges <= 0;
    else if (post_edges < 1000) post_edges <= post_edges + 1;
  end

  always @(negedge clk) begin
    logic [BN-1:0] exp_vld;
    bit            exp_rdy;
    if (!rst_n) begin
      m_lane   = 0;
      emit_due = 1'b0;
      exp_data = '0;
      for (int i = 0; i < int'(BN); i++) begin m_val[i] = 0; m_w[i] = 1'b0; end
      check("reset_rdy",  64'(bus.in_acc_rdy), 64'(0));
      check("reset_vld",  64'(bus.out_fixed_data_vld), 64'(0));
      check("reset_data", 64'(bus.out_fixed_data), 64'(0));
    end else begin
      exp_vld = emit_due ? pend_vld : '0;
      if (emit_due) exp_data = pend_data;
      exp_rdy = (post_edges > 0) && !emit_due;
      check("model_rdy",  64'(bus.in_acc_rdy), 64'(exp_rdy));
      check("model_vld",  64'(bus.out_fixed_data_vld), 64'(exp_vld));
      check("model_data", 64'(bus.out_fixed_data), 64'(exp_data));
      if (bus.out_fixed_data_vld != '0) emit_cnt++;
      emit_due = 1'b0;
      if (bus.in_acc_vld && exp_rdy) begin
        if (m_lane == 0) m_shift = int'(bus.cfg_shift);
        m_val[m_lane] = requant(int'($signed(bus.in_acc_data)), m_shift);
        m_w[m_lane]   = 1'b1;
        m_lane++;
        if (m_lane == int'(BN) || bus.in_acc_last) begin
          for (int i = 0; i < int'(BN); i++) begin
            pend_data[i*FW +: FW] = m_w[i] ? FW'(m_val[i]) : '0;
            pend_vld[i] = m_w[i];
            m_val[i] = 0;
            m_w[i]   = 1'b0;
          end
          m_lane   = 0;
          emit_due = 1'b1;
        end
      end
    end
  end

  task automatic send(input int acc, input bit last, input int sh);
    int n;
    bit got;
    bus.in_acc_data = AW'(acc);
    bus.in_acc_last = last;
    bus.cfg_shift   = SW'(sh);
    bus.in_acc_vld  = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = bus.in_acc_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accepted", 64'(got), 64'(1));
  endtask

  task automatic idle();
    bus.in_acc_vld  = 1'b0;
    bus.in_acc_last = 1'b0;
  endtask

  task automatic wait_emit(input string name, input logic [BN-1:0] vld,
                           input int l0, input int l1, input int l2, input int l3);
    int exp_l [BN];
    int n;
    exp_l[0] = l0; exp_l[1] = l1; exp_l[2] = l2; exp_l[3] = l3;
    n = 0;
    @(negedge clk);
    while (bus.out_fixed_data_vld == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_vld"}, 64'(bus.out_fixed_data_vld), 64'(vld));
    check({name, "_rdy"}, 64'(bus.in_acc_rdy), 64'(0));
    for (int i = 0; i < int'(BN); i++)
      check($sformatf("%s_lane%0d", name, i),
            64'(bus.out_fixed_data[i*FW +: FW]), 64'(lane8(exp_l[i])));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bus.in_acc_vld  = 1'b0;
    bus.in_acc_last = 1'b0;
    bus.in_acc_data = '0;
    bus.cfg_shift   = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("por_vld",  64'(bus.out_fixed_data_vld), 64'(0));
    check("por_data", 64'(bus.out_fixed_data), 64'(0));
    rst_n = 1'b1;
    #1 check("rel_rdy_low", 64'(bus.in_acc_rdy), 64'(0));
    @(posedge clk);
    #1 check("rel_rdy_high", 64'(bus.in_acc_rdy), 64'(1));

    // Full vector with truncation and positive saturation
    send(256, 1'b0, 2);
    send(-256, 1'b0, 2);
    send(1000, 1'b0, 2);
    send(40, 1'b0, 2);
    idle();
    wait_emit("full", 4'b1111, 64, -64, 127, 10);

    // Rounding versus truncation
    send(6, 1'b1, 2);
    idle();
    wait_emit("round_pos", 4'b0001, ROUND ? 2 : 1, 0, 0, 0);
    send(-6, 1'b1, 2);
    idle();
    wait_emit("round_neg", 4'b0001, ROUND ? -1 : -2, 0, 0, 0);

    // Partial vector, then the next vector restarts at lane 0
    send(5, 1'b0, 0);
    send(7, 1'b1, 0);
    idle();
    wait_emit("partial", 4'b0011, 5, 7, 0, 0);
    send(9, 1'b1, 0);
    idle();
    wait_emit("restart", 4'b0001, 9, 0, 0, 0);

    // Continuous valid for two vectors; shift changes after lane 0 are ignored
    e0 = emit_cnt;
    send(20, 1'b0, 1);
    send(40, 1'b0, 3);
    send(60, 1'b0, 3);
    send(80, 1'b0, 3);
    send(100, 1'b0, 0);
    send(120, 1'b0, 5);
    send(140, 1'b0, 5);
    send(160, 1'b0, 5);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("stream_emits", 64'(emit_cnt - e0), 64'(2));
    check("held_lane0", 64'(bus.out_fixed_data[0 +: FW]), 64'(lane8(100)));
    check("held_lane3", 64'(bus.out_fixed_data[3*FW +: FW]), 64'(lane8(127)));
    check("held_vld", 64'(bus.out_fixed_data_vld), 64'(0));

    // Reset in the middle of a vector
    send(11, 1'b0, 0);
    send(12, 1'b0, 0);
    idle();
    e0 = emit_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_vld",  64'(bus.out_fixed_data_vld), 64'(0));
    check("midrst_data", 64'(bus.out_fixed_data), 64'(0));
    check("midrst_rdy",  64'(bus.in_acc_rdy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("midrst_rel_rdy_low", 64'(bus.in_acc_rdy), 64'(0));
    @(posedge clk);
    #1 check("midrst_rel_rdy_high", 64'(bus.in_acc_rdy), 64'(1));
    send(1, 1'b0, 0);
    send(2, 1'b0, 0);
    send(3, 1'b0, 0);
    send(4, 1'b0, 0);
    idle();
    wait_emit("post_rst", 4'b1111, 1, 2, 3, 4);
    check("post_rst_emits", 64'(emit_cnt - e0), 64'(1));

    // Negative saturation
    send(-100000, 1'b1, 0);
    idle();
    wait_emit("neg_sat", 4'b0001, -128, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
